sargantana_icache_refill: RTL and testbench
===========================================

SARGANTANA_ICACHE_REFILL -- requirements
Module: sargantana_icache_refill

Interface
REQ-001 Parameter N_BEATS, default 4: refill beats per cache line; N_BEATS*FETCH_WIDHT SHALL equal WAY_WIDHT.
REQ-002 Parameter RR_INIT, default 0: reset value of the round-robin victim pointer.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rstn_i  in  1  reset, asynchronous, active-low.
REQ-005 miss_i  in  1  miss request; sampled only in IDLE.
REQ-006 miss_tag_i  in  ICACHE_TAG_WIDTH  physical tag of the missing line.
REQ-007 miss_idx_i  in  ICACHE_IDX_WIDTH  set index of the missing line.
REQ-008 way_valid_bits_i  in  ICACHE_N_WAY  valid bits of the addressed set, sampled with miss_i.
REQ-009 flush_i  in  1  invalidate request; kills any refill in progress.
REQ-010 ifill_req_valid_o  out  1  / ifill_req_ready_i  in  1  line-request handshake to the next level.
REQ-011 ifill_req_tag_o  out  ICACHE_TAG_WIDTH  / ifill_req_idx_o  out  ICACHE_IDX_WIDTH  latched miss address.
REQ-012 ifill_resp_valid_i  in  1  / ifill_resp_data_i  in  FETCH_WIDHT  one response beat per valid cycle, in ascending chunk order.
REQ-013 tag_we_o, data_we_o  out  1 each  one-cycle write strobes to the tag and data arrays.
REQ-014 wr_way_o  out  ICACHE_N_WAY  one-hot victim way; wr_idx_o  out  ICACHE_IDX_WIDTH; wr_tag_o  out  TAG_WIDHT; wr_data_o  out  WAY_WIDHT.
REQ-015 busy_o  out  1  refill in progress; done_o  out  1  one-cycle pulse when the line is written.

Function
REQ-016 FSM states: IDLE, REQ, RECV, WRITE.
REQ-017 IDLE: miss_i=1 and flush_i=0 -> latch tag, idx, victim; go to REQ next cycle; otherwise stay.
REQ-018 Victim: lowest-index way with valid bit 0; if all ways valid, way given by the round-robin pointer.
REQ-019 Round-robin pointer advances by 1 modulo ICACHE_N_WAY only when it supplied the victim and the write occurs.
REQ-020 REQ: ifill_req_valid_o=1, address stable, until ifill_req_ready_i=1; then RECV, beat counter=0.
REQ-021 RECV: each ifill_resp_valid_i beat k is stored at line bits [FETCH_WIDHT*(k+1)-1 : FETCH_WIDHT*k]; counter increments, wraps to 0 after beat N_BEATS-1.
REQ-022 After beat N_BEATS-1 -> WRITE; WRITE lasts exactly one cycle with tag_we_o=data_we_o=done_o=1, then IDLE.
REQ-023 Latency: miss_i accepted in cycle 0 -> ifill_req_valid_o in cycle 1; last beat in cycle n -> write strobes in cycle n+1.
REQ-024 busy_o=1 in REQ, RECV and WRITE; miss_i ignored while busy_o=1.
REQ-025 flush_i in REQ: drop the request, return to IDLE next cycle, no write.
REQ-026 flush_i in RECV: set kill flag, keep draining all N_BEATS beats, then return to IDLE with no write strobes and no done_o.
REQ-027 flush_i in WRITE: write suppressed; FSM returns to IDLE.
REQ-028 flush_i and miss_i together in IDLE: flush wins, miss is dropped.
REQ-029 ifill_resp_valid_i outside RECV is ignored.
REQ-030 wr_* outputs hold the latched values during WRITE; they are don't-care otherwise, and all strobes are 0 outside WRITE.

Reset
REQ-031 rstn_i low -> state IDLE, beat counter 0, kill flag 0, pointer RR_INIT, all strobes, valids, busy_o and done_o 0, line buffer 0.
REQ-032 Reset asserted mid-refill abandons the refill immediately with no write; outstanding beats after reset release are ignored per REQ-029.

Structure
REQ-033 sargantana_icache_pkg holds ICACHE_N_WAY, ICACHE_TAG_WIDTH, TAG_WIDHT, WAY_WIDHT, FETCH_WIDHT, ICACHE_IDX_WIDTH and the refill state enum type.
REQ-034 Invalid-way search SHALL instantiate sargantana_icache_tzc_idx on the inverted valid bits; no other sub-modules.

Verification
REQ-035 Valid bits 4'b1011, miss tag 0x1A2, idx 5, ready=1, 4 back-to-back beats A,B,C,D -> wr_way_o=4'b0100, wr_data_o={D,C,B,A}, strobes exactly 1 cycle after beat D.
REQ-036 Valid bits 4'b1111 on three consecutive misses with RR_INIT=0 -> victims 0001, 0010, 0100.
REQ-037 Stall ifill_req_ready_i for 5 cycles -> ifill_req_valid_o held 5 cycles with address stable; beats gapped by idle cycles -> correct chunk placement.
REQ-038 flush_i after beat 1 -> all 4 beats consumed, no tag_we_o, no done_o, pointer unchanged, busy_o low the cycle after beat 3.
REQ-039 Second miss_i pulse while busy -> ignored, only one ifill request issued.
REQ-040 rstn_i asserted during RECV -> outputs at reset values asynchronously; stray beats after release produce no write.

Source files
------------

// File: rtl/sargantana_icache_pkg.sv
// Shared geometry, refill FSM state type and helpers for the instruction-cache refill path.
package sargantana_icache_pkg;

    localparam int ICACHE_N_WAY     = 4;
    localparam int ICACHE_TAG_WIDTH = 20;
    localparam int TAG_WIDHT        = ICACHE_TAG_WIDTH;
    localparam int ICACHE_IDX_WIDTH = 6;
    localparam int FETCH_WIDHT      = 32;
    localparam int WAY_WIDHT        = 128;
    localparam int WAY_IDX_WIDTH    = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1;

    typedef enum logic [1:0] {
        REFILL_IDLE  = 2'd0,
        REFILL_REQ   = 2'd1,
        REFILL_RECV  = 2'd2,
        REFILL_WRITE = 2'd3
    } refill_state_t;

    function automatic logic [ICACHE_N_WAY-1:0] way_onehot(input logic [WAY_IDX_WIDTH-1:0] idx);
        logic [ICACHE_N_WAY-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/sargantana_icache_tzc_idx.sv
// Trailing-zero count: index of the lowest set bit, with a flag when no bit is set.
module sargantana_icache_tzc_idx #(
    parameter int WIDTH = 4,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             empty_o
);

    // Scan from the top so the lowest set bit is the last one to win.
    always_comb begin
        idx_o   = '0;
        empty_o = 1'b1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                idx_o   = IDX_W'(i);
                empty_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sargantana_icache_refill.sv
// I-cache line refill: picks a victim way, requests the line, gathers the beats and writes tag+data.
//
// state        | meaning
// REFILL_IDLE  | waiting for a miss; victim chosen from the sampled valid bits
// REFILL_REQ   | line request held towards the next level until ready
// REFILL_RECV  | collecting N_BEATS response beats (drained even when killed)
// REFILL_WRITE | one-cycle tag/data write strobe and done pulse
module sargantana_icache_refill
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned N_BEATS = 4,
    parameter int unsigned RR_INIT = 0
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        miss_i,
    input  logic [ICACHE_TAG_WIDTH-1:0] miss_tag_i,
    input  logic [ICACHE_IDX_WIDTH-1:0] miss_idx_i,
    input  logic [ICACHE_N_WAY-1:0]     way_valid_bits_i,
    input  logic                        flush_i,
    output logic                        ifill_req_valid_o,
    input  logic                        ifill_req_ready_i,
    output logic [ICACHE_TAG_WIDTH-1:0] ifill_req_tag_o,
    output logic [ICACHE_IDX_WIDTH-1:0] ifill_req_idx_o,
    input  logic                        ifill_resp_valid_i,
    input  logic [FETCH_WIDHT-1:0]      ifill_resp_data_i,
    output logic                        tag_we_o,
    output logic                        data_we_o,
    output logic [ICACHE_N_WAY-1:0]     wr_way_o,
    output logic [ICACHE_IDX_WIDTH-1:0] wr_idx_o,
    output logic [TAG_WIDHT-1:0]        wr_tag_o,
    output logic [WAY_WIDHT-1:0]        wr_data_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int CNT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CNT_W-1:0]         LAST_BEAT = CNT_W'(N_BEATS - 1);
    localparam logic [WAY_IDX_WIDTH-1:0] RR_RESET  = WAY_IDX_WIDTH'(RR_INIT);
    localparam logic [WAY_IDX_WIDTH-1:0] RR_LAST   = WAY_IDX_WIDTH'(ICACHE_N_WAY - 1);

    refill_state_t               state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        kill_q;
    logic [WAY_IDX_WIDTH-1:0]    rr_q;
    logic                        from_rr_q;
    logic [ICACHE_N_WAY-1:0]     way_q;
    logic [ICACHE_TAG_WIDTH-1:0] tag_q;
    logic [ICACHE_IDX_WIDTH-1:0] idx_q;
    logic [WAY_WIDHT-1:0]        line_q;
    logic                        req_valid_q;
    logic                        busy_q;
    logic                        write_q;

    logic [WAY_IDX_WIDTH-1:0]    free_idx;
    logic                        no_free;
    logic [WAY_IDX_WIDTH-1:0]    victim_idx;

    sargantana_icache_tzc_idx #(
        .WIDTH (ICACHE_N_WAY),
        .IDX_W (WAY_IDX_WIDTH)
    ) u_tzc_idx (
        .in_i    (~way_valid_bits_i),
        .idx_o   (free_idx),
        .empty_o (no_free)
    );

    assign victim_idx = no_free ? rr_q : free_idx;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= REFILL_IDLE;
            cnt_q       <= '0;
            kill_q      <= 1'b0;
            rr_q        <= RR_RESET;
            from_rr_q   <= 1'b0;
            way_q       <= '0;
            tag_q       <= '0;
            idx_q       <= '0;
            line_q      <= '0;
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            write_q     <= 1'b0;
        end else begin
            write_q <= 1'b0;
            case (state_q)
                REFILL_IDLE: begin
                    if (miss_i && !flush_i) begin
                        tag_q       <= miss_tag_i;
                        idx_q       <= miss_idx_i;
                        way_q       <= way_onehot(victim_idx);
                        from_rr_q   <= no_free;
                        kill_q      <= 1'b0;
                        req_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= REFILL_REQ;
                    end
                end
                REFILL_REQ: begin
                    // A flush wins over a same-cycle handshake; any beats that follow land in IDLE and are ignored.
                    if (flush_i) begin
                        req_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= REFILL_IDLE;
                    end else if (ifill_req_ready_i) begin
                        req_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= REFILL_RECV;
                    end
                end
                REFILL_RECV: begin
                    if (flush_i) begin
                        kill_q <= 1'b1;
                    end
                    if (ifill_resp_valid_i) begin
                        line_q[int'(cnt_q)*FETCH_WIDHT +: FETCH_WIDHT] <= ifill_resp_data_i;
                        if (cnt_q == LAST_BEAT) begin
                            cnt_q <= '0;
                            if (kill_q || flush_i) begin
                                kill_q  <= 1'b0;
                                busy_q  <= 1'b0;
                                state_q <= REFILL_IDLE;
                            end else begin
                                write_q <= 1'b1;
                                state_q <= REFILL_WRITE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                REFILL_WRITE: begin
                    if (from_rr_q && !flush_i) begin
                        rr_q <= (rr_q == RR_LAST) ? '0 : rr_q + 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= REFILL_IDLE;
                end
                default: begin
                    busy_q      <= 1'b0;
                    req_valid_q <= 1'b0;
                    state_q     <= REFILL_IDLE;
                end
            endcase
        end
    end

    // Strobes are registered; a flush arriving during the write cycle masks them.
    assign tag_we_o          = write_q & ~flush_i;
    assign data_we_o         = write_q & ~flush_i;
    assign done_o            = write_q & ~flush_i;
    assign busy_o            = busy_q;
    assign ifill_req_valid_o = req_valid_q;
    assign ifill_req_tag_o   = tag_q;
    assign ifill_req_idx_o   = idx_q;
    assign wr_way_o          = way_q;
    assign wr_idx_o          = idx_q;
    assign wr_tag_o          = tag_q;
    assign wr_data_o         = line_q;

endmodule

// File: tb/tb_sargantana_icache_refill.sv
// Scoreboard bench for the i-cache refill FSM: expected writes queued at stimulus time, observed writes queued by a monitor.
module tb_sargantana_icache_refill;
    import sargantana_icache_pkg::*;

    localparam int NB = 4;

    logic                        clk_i = 1'b0;
    logic                        rstn_i = 1'b0;
    logic                        miss_i = 1'b0;
    logic [ICACHE_TAG_WIDTH-1:0] miss_tag_i = '0;
    logic [ICACHE_IDX_WIDTH-1:0] miss_idx_i = '0;
    logic [ICACHE_N_WAY-1:0]     way_valid_bits_i = '0;
    logic                        flush_i = 1'b0;
    logic                        ifill_req_valid_o;
    logic                        ifill_req_ready_i = 1'b1;
    logic [ICACHE_TAG_WIDTH-1:0] ifill_req_tag_o;
    logic [ICACHE_IDX_WIDTH-1:0] ifill_req_idx_o;
    logic                        ifill_resp_valid_i = 1'b0;
    logic [FETCH_WIDHT-1:0]      ifill_resp_data_i = '0;
    logic                        tag_we_o, data_we_o, done_o, busy_o;
    logic [ICACHE_N_WAY-1:0]     wr_way_o;
    logic [ICACHE_IDX_WIDTH-1:0] wr_idx_o;
    logic [TAG_WIDHT-1:0]        wr_tag_o;
    logic [WAY_WIDHT-1:0]        wr_data_o;

    sargantana_icache_refill #(.N_BEATS(NB), .RR_INIT(0)) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .miss_i             (miss_i),
        .miss_tag_i         (miss_tag_i),
        .miss_idx_i         (miss_idx_i),
        .way_valid_bits_i   (way_valid_bits_i),
        .flush_i            (flush_i),
        .ifill_req_valid_o  (ifill_req_valid_o),
        .ifill_req_ready_i  (ifill_req_ready_i),
        .ifill_req_tag_o    (ifill_req_tag_o),
        .ifill_req_idx_o    (ifill_req_idx_o),
        .ifill_resp_valid_i (ifill_resp_valid_i),
        .ifill_resp_data_i  (ifill_resp_data_i),
        .tag_we_o           (tag_we_o),
        .data_we_o          (data_we_o),
        .wr_way_o           (wr_way_o),
        .wr_idx_o           (wr_idx_o),
        .wr_tag_o           (wr_tag_o),
        .wr_data_o          (wr_data_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [2:0]                  strb;
        logic [ICACHE_N_WAY-1:0]     way;
        logic [ICACHE_IDX_WIDTH-1:0] idx;
        logic [TAG_WIDHT-1:0]        tag;
        logic [WAY_WIDHT-1:0]        data;
        logic [31:0]                 cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  cyc = 0;
    int  hs_count = 0;
    int  wr_count = 0;
    int  passed = 0;
    int  total = 0;

    always @(posedge clk_i) cyc++;

    always @(negedge clk_i) begin
        if (ifill_req_valid_o && ifill_req_ready_i) hs_count++;
        if (tag_we_o || data_we_o || done_o) begin
            wr_count++;
            obs_q.push_back('{strb: {tag_we_o, data_we_o, done_o}, way: wr_way_o, idx: wr_idx_o,
                              tag: wr_tag_o, data: wr_data_o, cyc: 32'(cyc)});
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Presents a one-cycle miss; returns in the first REQ cycle.
    task automatic issue_miss(input logic [ICACHE_N_WAY-1:0] vb, input logic [ICACHE_TAG_WIDTH-1:0] tag,
                              input logic [ICACHE_IDX_WIDTH-1:0] idx);
        miss_i           = 1'b1;
        way_valid_bits_i = vb;
        miss_tag_i       = tag;
        miss_idx_i       = idx;
        tick();
        miss_i = 1'b0;
    endtask

    // Drives the line beats from RECV, queues the expected write, returns in IDLE.
    task automatic send_line(input logic [ICACHE_TAG_WIDTH-1:0] tag, input logic [ICACHE_IDX_WIDTH-1:0] idx,
                             input logic [ICACHE_N_WAY-1:0] way, input logic [WAY_WIDHT-1:0] line, input int gap);
        int bc;
        for (int k = 0; k < NB; k++) begin
            ifill_resp_valid_i = 1'b1;
            ifill_resp_data_i  = line[k*FETCH_WIDHT +: FETCH_WIDHT];
            bc = cyc;
            tick();
            ifill_resp_valid_i = 1'b0;
            if (k == NB - 1) exp_q.push_back('{strb: 3'b111, way: way, idx: idx, tag: tag, data: line, cyc: 32'(bc + 1)});
            else repeat (gap) tick();
        end
        tick();
    endtask

    task automatic full_refill(input logic [ICACHE_N_WAY-1:0] vb, input logic [ICACHE_TAG_WIDTH-1:0] tag,
                               input logic [ICACHE_IDX_WIDTH-1:0] idx, input logic [ICACHE_N_WAY-1:0] way,
                               input logic [WAY_WIDHT-1:0] line);
        issue_miss(vb, tag, idx);
        tick();
        send_line(tag, idx, way, line, 0);
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        repeat (3) @(negedge clk_i);
        total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy_o); else passed++;
        total++; if (ifill_req_valid_o !== 1'b0) $display("FAIL reset_req_valid: got %b required 0", ifill_req_valid_o); else passed++;
        total++; if (tag_we_o !== 1'b0) $display("FAIL reset_tag_we: got %b required 0", tag_we_o); else passed++;
        total++; if (data_we_o !== 1'b0) $display("FAIL reset_data_we: got %b required 0", data_we_o); else passed++;
        total++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b required 0", done_o); else passed++;
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int  hs0 = hs_count;
        wr_t e, o;
        full_refill(4'b1011, 20'h001A2, 6'd5, 4'b0100, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL basic_write: no write seen, required %p", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL basic_write: got %p required %p", o, e); else passed++; end
        end
        total++; if (hs_count - hs0 !== 1) $display("FAIL basic_requests: got %0d required 1", hs_count - hs0); else passed++;
        total++; if (busy_o !== 1'b0) $display("FAIL basic_busy_after: got %b required 0", busy_o); else passed++;
    endtask

    task automatic test_round_robin();
        logic [ICACHE_N_WAY-1:0] ways [3] = '{4'b0001, 4'b0010, 4'b0100};
        int  hs0 = hs_count;
        wr_t e, o;
        for (int i = 0; i < 3; i++) begin
            full_refill(4'b1111, 20'(32'h100 + i), 6'(10 + i), ways[i], {$urandom, $urandom, $urandom, $urandom});
            tick();
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL rr_write: no write seen, required %p", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL rr_write: got %p required %p", o, e); else passed++; end
        end
        total++; if (hs_count - hs0 !== 3) $display("FAIL rr_requests: got %0d required 3", hs_count - hs0); else passed++;
    endtask

    task automatic test_flush_recv();
        int  hs0 = hs_count;
        int  wr0 = wr_count;
        wr_t e, o;
        issue_miss(4'b1111, 20'h0BEEF, 6'd20);
        tick();
        for (int k = 0; k < NB; k++) begin
            ifill_resp_valid_i = 1'b1;
            ifill_resp_data_i  = $urandom;
            tick();
            ifill_resp_valid_i = 1'b0;
            if (k == 1) begin
                flush_i = 1'b1;
                tick();
                flush_i = 1'b0;
            end
            if (k == 2) begin
                total++; if (busy_o !== 1'b1) $display("FAIL flush_recv_draining: busy got %b required 1", busy_o); else passed++;
            end
        end
        total++; if (busy_o !== 1'b0) $display("FAIL flush_recv_busy_after_last: got %b required 0", busy_o); else passed++;
        repeat (2) tick();
        total++; if (wr_count !== wr0) $display("FAIL flush_recv_no_write: writes got %0d required %0d", wr_count, wr0); else passed++;
        total++; if (hs_count - hs0 !== 1) $display("FAIL flush_recv_requests: got %0d required 1", hs_count - hs0); else passed++;
        // Pointer was 3 before the killed refill; it must still supply way 3.
        full_refill(4'b1111, 20'h0CAFE, 6'd21, 4'b1000, {$urandom, $urandom, $urandom, $urandom});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL flush_recv_rr_kept: no write seen, required %p", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL flush_recv_rr_kept: got %p required %p", o, e); else passed++; end
        end
    endtask

    task automatic test_flush_write();
        int  wr0 = wr_count;
        wr_t e, o;
        issue_miss(4'b1111, 20'h01111, 6'd30);
        tick();
        for (int k = 0; k < NB; k++) begin
            ifill_resp_valid_i = 1'b1;
            ifill_resp_data_i  = $urandom;
            tick();
            ifill_resp_valid_i = 1'b0;
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        total++; if (wr_count !== wr0) $display("FAIL flush_write_suppressed: writes got %0d required %0d", wr_count, wr0); else passed++;
        total++; if (busy_o !== 1'b0) $display("FAIL flush_write_idle: busy got %b required 0", busy_o); else passed++;
        full_refill(4'b1111, 20'h02222, 6'd31, 4'b0001, {$urandom, $urandom, $urandom, $urandom});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL flush_write_rr_kept: no write seen, required %p", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL flush_write_rr_kept: got %p required %p", o, e); else passed++; end
        end
    endtask

    task automatic test_stall_gaps();
        logic [ICACHE_TAG_WIDTH-1:0] tg = 20'h3C3C3;
        logic [ICACHE_IDX_WIDTH-1:0] ix = 6'd33;
        wr_t e, o;
        ifill_req_ready_i = 1'b0;
        issue_miss(4'b0000, tg, ix);
        miss_tag_i = ~tg;
        miss_idx_i = ~ix;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({ifill_req_valid_o, ifill_req_tag_o, ifill_req_idx_o} !== {1'b1, tg, ix})
                $display("FAIL stall_req_hold%0d: got v=%b tag=%h idx=%0d required v=1 tag=%h idx=%0d",
                         i, ifill_req_valid_o, ifill_req_tag_o, ifill_req_idx_o, tg, ix);
            else passed++;
            tick();
        end
        ifill_req_ready_i = 1'b1;
        total++; if (ifill_req_valid_o !== 1'b1) $display("FAIL stall_req_at_ready: got %b required 1", ifill_req_valid_o); else passed++;
        tick();
        total++; if ({ifill_req_valid_o, busy_o} !== 2'b01) $display("FAIL stall_req_dropped: got v=%b busy=%b required v=0 busy=1", ifill_req_valid_o, busy_o); else passed++;
        send_line(tg, ix, 4'b0001, {$urandom, $urandom, $urandom, $urandom}, 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL stall_gap_write: no write seen, required %p", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL stall_gap_write: got %p required %p", o, e); else passed++; end
        end
    endtask

    task automatic test_double_miss();
        int  hs0 = hs_count;
        wr_t e, o;
        issue_miss(4'b1110, 20'h0AAAA, 6'd7);
        miss_i           = 1'b1;
        miss_tag_i       = 20'h05555;
        miss_idx_i       = 6'd8;
        way_valid_bits_i = 4'b0000;
        tick();
        send_line(20'h0AAAA, 6'd7, 4'b0001, {$urandom, $urandom, $urandom, $urandom}, 0);
        miss_i = 1'b0;
        repeat (3) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL double_miss_write: no write seen, required %p", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL double_miss_write: got %p required %p", o, e); else passed++; end
        end
        total++; if (hs_count - hs0 !== 1) $display("FAIL double_miss_requests: got %0d required 1", hs_count - hs0); else passed++;
        total++; if (obs_q.size() !== 0) $display("FAIL double_miss_extra_write: got %0d extra required 0", obs_q.size()); else passed++;
    endtask

    task automatic test_flush_idle_req();
        int hs0 = hs_count;
        int wr0 = wr_count;
        miss_i  = 1'b1;
        flush_i = 1'b1;
        way_valid_bits_i = 4'b0000;
        tick();
        miss_i  = 1'b0;
        flush_i = 1'b0;
        total++; if ({busy_o, ifill_req_valid_o} !== 2'b00) $display("FAIL flush_idle_miss_dropped: got busy=%b v=%b required 0 0", busy_o, ifill_req_valid_o); else passed++;
        ifill_req_ready_i = 1'b0;
        issue_miss(4'b0000, 20'h0F0F0, 6'd40);
        total++; if (ifill_req_valid_o !== 1'b1) $display("FAIL flush_req_raised: got %b required 1", ifill_req_valid_o); else passed++;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        ifill_req_ready_i = 1'b1;
        total++; if ({busy_o, ifill_req_valid_o} !== 2'b00) $display("FAIL flush_req_dropped: got busy=%b v=%b required 0 0", busy_o, ifill_req_valid_o); else passed++;
        repeat (6) tick();
        total++; if ((hs_count - hs0) + (wr_count - wr0) !== 0) $display("FAIL flush_req_quiet: got %0d req/writes required 0", (hs_count - hs0) + (wr_count - wr0)); else passed++;
    endtask

    task automatic test_reset_mid();
        int  wr0;
        wr_t e, o;
        issue_miss(4'b1111, 20'h07777, 6'd50);
        tick();
        for (int k = 0; k < 2; k++) begin
            ifill_resp_valid_i = 1'b1;
            ifill_resp_data_i  = $urandom;
            tick();
        end
        ifill_resp_valid_i = 1'b0;
        #2 rstn_i = 1'b0;
        #1;
        total++;
        if ({busy_o, ifill_req_valid_o, tag_we_o, done_o} !== 4'b0000)
            $display("FAIL reset_mid_async: got busy=%b v=%b we=%b done=%b required all 0", busy_o, ifill_req_valid_o, tag_we_o, done_o);
        else passed++;
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
        wr0 = wr_count;
        for (int k = 0; k < NB; k++) begin
            ifill_resp_valid_i = 1'b1;
            ifill_resp_data_i  = $urandom;
            tick();
        end
        ifill_resp_valid_i = 1'b0;
        repeat (2) tick();
        total++; if (wr_count !== wr0) $display("FAIL reset_mid_stray_beats: writes got %0d required %0d", wr_count, wr0); else passed++;
        total++; if (busy_o !== 1'b0) $display("FAIL reset_mid_idle: busy got %b required 0", busy_o); else passed++;
        // Pointer was 1 before reset; reset must return it to way 0.
        full_refill(4'b1111, 20'h08888, 6'd51, 4'b0001, {$urandom, $urandom, $urandom, $urandom});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL reset_mid_rr_init: no write seen, required %p", e);
            else begin o = obs_q.pop_front(); if (o !== e) $display("FAIL reset_mid_rr_init: got %p required %p", o, e); else passed++; end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_flush_recv();
        test_flush_write();
        test_stall_gaps();
        test_double_miss();
        test_flush_idle_req();
        test_reset_mid();
        repeat (3) tick();
        total++;
        if (exp_q.size() + obs_q.size() !== 0)
            $display("FAIL scoreboard_drained: got %0d expected and %0d observed left, required 0 0", exp_q.size(), obs_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
